// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Brief  : Shared types, mode constants and compare-mask helper for seq_detector_param.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HUNT = 1'b1
  } state_e;

  localparam logic MODE_OVERLAP    = 1'b0;
  localparam logic MODE_NONOVERLAP = 1'b1;

  // Ones in the low len bits; callers truncate to their own pattern width.
  function automatic logic [31:0] len_mask(input int len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear; clear-plus-inc yields 1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign cnt_o = count_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module : seq_detector_param
// Brief  : Runtime-programmable serial pattern detector with overlap/non-overlap
//          modes and a saturating match counter. SEQDET_MASK_EN adds cfg_mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'h7,
  parameter int                 DEF_LEN     = 3,
  parameter int                 CNT_W       = 8,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_mode,
  input  logic               cnt_clr,
`ifdef SEQDET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy_fill
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               mode_q, mode_d;
  logic               dout_q, dout_d;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_cmp_mask;
  logic [MAX_LEN-1:0] w_dc_mask;
  logic [LW-1:0]      w_len_clamped;
  logic [LW-1:0]      w_fill_inc;
  logic               w_full;
  logic               w_hit;
  logic               w_match;

`ifdef SEQDET_MASK_EN
  logic [MAX_LEN-1:0] mask_q, mask_d;
  assign w_dc_mask = mask_q;
`else
  assign w_dc_mask = '0;
`endif

  assign w_hist_next   = {hist_q[MAX_LEN-2:0], din};
  assign w_len_clamped = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
  assign w_cmp_mask    = MAX_LEN'(len_mask(int'(len_q)));
  assign w_fill_inc    = fill_q + 1'b1;

  // The bit that completes the fill window is already eligible to match.
  assign w_full  = (state_q == ST_HUNT) || (w_fill_inc == len_q);
  assign w_hit   = (((w_hist_next ^ pat_q) & w_cmp_mask & ~w_dc_mask) == '0);
  assign w_match = din_valid && !cfg_load && (len_q != '0) && w_full && w_hit;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    mode_d  = mode_q;
    dout_d  = w_match;
`ifdef SEQDET_MASK_EN
    mask_d  = mask_q;
`endif
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = w_len_clamped;
      mode_d  = cfg_mode;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_FILL;
`ifdef SEQDET_MASK_EN
      mask_d  = cfg_mask;
`endif
    end else if (din_valid) begin
      hist_d = w_hist_next;
      if (w_match && (mode_q == MODE_NONOVERLAP)) begin
        state_d = ST_FILL;
        fill_d  = '0;
      end else if ((state_q == ST_FILL) && (len_q != '0)) begin
        fill_d = w_fill_inc;
        if (w_full) state_d = ST_HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      mode_q  <= MODE_OVERLAP;
      dout_q  <= 1'b0;
`ifdef SEQDET_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
`ifdef SEQDET_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_match),
    .clr_i (cnt_clr),
    .cnt_o (match_cnt)
  );

  assign dout      = dout_q;
  assign busy_fill = (state_q == ST_FILL);

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module : tb_seq_detector_param
// Brief  : Directed scoreboard bench for seq_detector_param (CNT_W=8 and CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_mode;
  logic       cnt_clr;
  logic [7:0] cfg_mask;

  logic       dout_a, busy_a;
  logic [7:0] cnt_a;
  logic       dout_b, busy_b;
  logic [1:0] cnt_b;

  int   checks;
  int   failures;
  logic exp_q[$];

  seq_detector_param #(.MAX_LEN(8), .DEF_PATTERN(8'h07), .DEF_LEN(3), .CNT_W(8)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_mode    (cfg_mode),
    .cnt_clr     (cnt_clr),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .dout        (dout_a),
    .match_cnt   (cnt_a),
    .busy_fill   (busy_a)
  );

  seq_detector_param #(.MAX_LEN(8), .DEF_PATTERN(8'h07), .DEF_LEN(3), .CNT_W(2)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_mode    (cfg_mode),
    .cnt_clr     (cnt_clr),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .dout        (dout_b),
    .match_cnt   (cnt_b),
    .busy_fill   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected dout, compare after the edge.
  task automatic step(input logic d, input logic v, input logic clr, input logic exp);
    logic e;
    din       = d;
    din_valid = v;
    cnt_clr   = clr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    cnt_clr   = 1'b0;
    e = exp_q.pop_front();
    chk("dout_a", {31'b0, dout_a}, {31'b0, e});
    chk("dout_b", {31'b0, dout_b}, {31'b0, e});
  endtask

  // Sends n valid bits (bits[0] first); pulses[i] is the expected dout after bit i.
  task automatic stream(input int n, input logic [31:0] bits, input logic [31:0] pulses);
    for (int i = 0; i < n; i++) step(bits[i], 1'b1, 1'b0, pulses[i]);
  endtask

  // Config strobe with a valid '1' on din that must be discarded.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic mode,
                      input logic [7:0] msk);
    logic e;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_mode    = mode;
    cfg_mask    = msk;
    cfg_load    = 1'b1;
    din         = 1'b1;
    din_valid   = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
    e = exp_q.pop_front();
    chk("cfg_dout", {31'b0, dout_a}, {31'b0, e});
    chk("cfg_busy", {31'b0, busy_a}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_mode = 1'b0; cnt_clr = 1'b0; cfg_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dout", {31'b0, dout_a}, 32'd0);
    chk("rst_cnt", {24'b0, cnt_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd1);
    chk("rst_busy_b", {31'b0, busy_b}, 32'd1);

    // Legacy 111 overlapping from reset configuration
    stream(12, 32'h7DA, 32'h700);
    chk("legacy_cnt", {24'b0, cnt_a}, 32'd3);
    chk("legacy_busy", {31'b0, busy_a}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", {24'b0, cnt_a}, 32'd0);

    // 111 non-overlap, six ones
    load(8'h07, 4'd3, 1'b1, 8'h00);
    stream(6, 32'h3F, 32'h24);
    chk("nonovl_cnt", {24'b0, cnt_a}, 32'd2);

    // 1011 overlap then non-overlap
    load(8'h0B, 4'd4, 1'b0, 8'h00);
    stream(7, 32'h6D, 32'h48);
    chk("p1011_ovl_cnt", {24'b0, cnt_a}, 32'd4);
    load(8'h0B, 4'd4, 1'b1, 8'h00);
    stream(7, 32'h6D, 32'h08);
    chk("p1011_non_cnt", {24'b0, cnt_a}, 32'd5);

    // Reload after two matching bits discards them
    load(8'h07, 4'd3, 1'b0, 8'h00);
    stream(2, 32'h3, 32'h0);
    load(8'h07, 4'd3, 1'b0, 8'h00);
    stream(3, 32'h7, 32'h4);

    // Valid gaps inside the pattern; dout drops when no valid bit sampled
    load(8'h07, 4'd3, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_cnt", {24'b0, cnt_a}, 32'd7);

    // Saturation of the 2-bit counter, then clear-with-match
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr2_cnt_a", {24'b0, cnt_a}, 32'd0);
    load(8'h07, 4'd3, 1'b0, 8'h00);
    stream(7, 32'h7F, 32'h7C);
    chk("sat_cnt_a", {24'b0, cnt_a}, 32'd5);
    chk("sat_cnt_b", {30'b0, cnt_b}, 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clrmatch_a", {24'b0, cnt_a}, 32'd1);
    chk("clrmatch_b", {30'b0, cnt_b}, 32'd1);

    // Length 0 disables detection
    load(8'hFF, 4'd0, 1'b0, 8'h00);
    stream(5, 32'h1F, 32'h0);
    chk("len0_busy", {31'b0, busy_a}, 32'd1);
    chk("len0_cnt", {24'b0, cnt_a}, 32'd1);

    // Length above MAX_LEN clamps to 8
    load(8'hFF, 4'd15, 1'b0, 8'h00);
    stream(8, 32'hFF, 32'h80);

    // Reset mid-stream restores default configuration
    stream(2, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", {31'b0, busy_a}, 32'd1);
    chk("mrst_cnt", {24'b0, cnt_a}, 32'd0);
    chk("mrst_dout", {31'b0, dout_a}, 32'd0);
    stream(3, 32'h7, 32'h4);
    chk("mrst_busy2", {31'b0, busy_a}, 32'd0);

`ifdef SEQDET_MASK_EN
    load(8'h09, 4'd4, 1'b1, 8'h06);
    stream(4, 32'hF, 32'h8);
    load(8'h09, 4'd4, 1'b1, 8'h06);
    stream(4, 32'hD, 32'h8);
    load(8'h09, 4'd4, 1'b1, 8'h06);
    stream(4, 32'hE, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, successor to the fixed three-ones detector FSM. It detects a runtime-programmable pattern of 1..MAX_LEN bits on a qualified serial input stream. Supports overlapping and non-overlapping modes and counts matches in a saturating counter. Its reset configuration reproduces the legacy "111, overlapping" behaviour, so it drops into existing serial-monitor paths.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- DEF_PATTERN, 'h7: reset pattern. Bit 0 is the most recent bit.
- DEF_LEN, 3: reset pattern length (1..MAX_LEN).
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- cfg_load  in  1  single-cycle strobe; latches cfg_pattern, cfg_len and cfg_mode.
- cfg_pattern  in  MAX_LEN  pattern bits. Bit 0 is the newest bit, bit cfg_len-1 the oldest.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_mode  in  1  0 = overlapping, 1 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- dout  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- busy_fill  out  1  high while fewer than len valid bits have been received since the last restart.

Behaviour:
- Reset: history=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, mode=overlap, dout=0, match_cnt=0, busy_fill=1.
- State machine FILL -> HUNT:
  - FILL: each valid bit shifts into history (history <= {history[MAX_LEN-2:0], din}) and increments fill. Move to HUNT when fill reaches len.
  - HUNT: each valid bit shifts in. Match = (history_next[len-1:0] == pattern[len-1:0]).
- Latency: dout is high for exactly the one cycle after the edge that sampled the completing bit. It is never high when no valid bit was sampled on the previous edge.
- Overlap mode: stay in HUNT after a match. A continuous run of matching bits gives back-to-back dout pulses, so dout stays high while the run lasts.
- Non-overlap mode: on a match, return to FILL with fill=0. History bits may be kept but are ignored until len new valid bits have arrived.
- din_valid=0: history, fill, state and counter hold. dout=0 on the next cycle.
- cfg_load:
  - Latches the config, clears history and fill, and enters FILL.
  - Any din_valid in the same cycle is discarded.
  - dout=0 on the next cycle. match_cnt is not affected.
- Length rules: cfg_len=0 disables detection (dout never asserts, busy_fill=1). cfg_len>MAX_LEN is clamped to MAX_LEN.
- match_cnt:
  - Increments once per match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr alone gives 0.
  - cnt_clr together with a match gives 1 (clear, then count).
- rst mid-stream: all state returns to reset values on that edge, including config.

Optional Feature:
SEQDET_MASK_EN
- Defined: adds input port cfg_mask [MAX_LEN-1:0], latched on cfg_load. Bits set to 1 are don't-care in the comparison. Reset value of the mask is 0.
- Not defined: the port does not exist and every bit in len is compared exactly.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (ST_FILL, ST_HUNT);
  - the mode constants (MODE_OVERLAP=0, MODE_NONOVERLAP=1);
  - a function that builds a len-bit compare mask.
- One sub-module, sat_counter: parametrised width, with inc/clr/saturate. It instantiates match_cnt.

Test Plan:
- After reset, with the legacy stream 0,1,0,1,1,0,1,1,1,1,1,0 (all valid): dout pulses on the cycles after the 9th, 10th and 11th bits (a 3-cycle high run). match_cnt=3.
- Load pattern 'h7, len 3, non-overlap, then stream six 1s: dout pulses after bits 3 and 6 only. match_cnt=2.
- Load pattern 4'b1011, len 4, overlap, then stream 1,0,1,1,0,1,1: pulses after bits 4 and 7. Repeat in non-overlap mode: pulse after bit 4 only.
- Mid-stream checks:
  - cfg_load asserted after two matching bits of 111: those bits are discarded, and 111 must be re-sent in full before dout asserts.
  - din_valid gaps of 3 cycles inside the pattern do not break a match.
- CNT_W=2 with 5 matches: match_cnt saturates at 3. cnt_clr in the same cycle as a match gives 1.
- With SEQDET_MASK_EN: pattern 4'b1001, mask 4'b0110. Streams 1,1,1,1 and 1,0,1,1 both match, 0,1,1,1 does not.
